// File: rtl/instr_enc_loader_if.sv
// Stream and memory-write bundle for instr_enc_loader.
// master: the side producing field bundles and accepting memory writes (host/bench).
// slave : the loader itself.
interface instr_enc_loader_if #(
   parameter int ADDR_W = 32
);
   // Decoded field bundle stream
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_fmt;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [31:0]       in_imm;
   logic              in_last;

   // Instruction memory write port
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last,
      input  in_ready,
      input  mem_we, mem_addr, mem_wdata,
      output mem_ready
   );

   modport slave (
      input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last,
      output in_ready,
      output mem_we, mem_addr, mem_wdata,
      input  mem_ready
   );
endinterface

// File: rtl/instr_enc_loader.sv
// Instruction encoder/loader: packs decoded fields (S, I-load, I-ALU, B) into
// RV32I words and writes them to instruction memory at sequential addresses.
// Optional feature macro: ENC_RANGE_CHECK_EN -- when defined, bundles whose
// immediate does not fit the encoding are handshaken, dropped and flagged in err.
module instr_enc_loader #(
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   instr_enc_loader_if.slave   bus,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [15:0]         wr_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [1:0] FMT_STORE  = 2'b00;
   localparam logic [1:0] FMT_LOAD   = 2'b01;
   localparam logic [1:0] FMT_ALUI   = 2'b10;
   localparam logic [1:0] FMT_BRANCH = 2'b11;

   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_inc;
   logic [31:0]       imm;
   logic [31:0]       enc_word;
   logic              imm_ok;
   logic              accept;
   logic              wr_fire;

   assign imm     = bus.in_imm;
   assign ptr_inc = ptr + ADDR_W'(4);
   assign accept  = bus.in_valid && bus.in_ready;
   assign wr_fire = bus.mem_we && bus.mem_ready;

   // Accept only while running and the output register is free or draining this cycle;
   // start has priority so a restart never races with a new bundle.
   assign bus.in_ready = (state == RUN) && (!bus.mem_we || bus.mem_ready) && !start;

`ifdef ENC_RANGE_CHECK_EN
   logic i_fits;
   logic b_fits;
   assign i_fits = (&imm[31:11]) || !(|imm[31:11]);
   assign b_fits = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
   assign imm_ok = (bus.in_fmt == FMT_BRANCH) ? b_fits : i_fits;
`else
   // Every bundle is written; out-of-range immediates are truncated by the packing.
   assign imm_ok = 1'b1;
`endif

   // Pack the field bundle into an RV32I word according to its format.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves enc_word unassigned (no latch).
      enc_word = '0;
      case (bus.in_fmt)
         FMT_STORE:  enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OP_STORE};
         FMT_LOAD:   enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
         FMT_ALUI:   enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_ALUI};
         FMT_BRANCH: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                 imm[4:1], imm[11], OP_BRANCH};
         default:    enc_word = '0;
      endcase
   end

   // Session FSM, address pointer, output register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         wr_count      <= '0;
         ptr           <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else if (start) begin
         state      <= RUN;
         busy       <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         wr_count   <= '0;
         ptr        <= base_addr;
         bus.mem_we <= 1'b0;
      end else begin
         done <= 1'b0;

         if (wr_fire) begin
            ptr        <= ptr_inc;
            bus.mem_we <= 1'b0;
            if (wr_count != 16'hFFFF)
               wr_count <= wr_count + 16'd1;
         end

         if (accept) begin
            if (imm_ok) begin
               bus.mem_we    <= 1'b1;
               bus.mem_addr  <= wr_fire ? ptr_inc : ptr;
               bus.mem_wdata <= enc_word;
            end else begin
               err <= 1'b1;
            end
         end

         case (state)
            RUN: begin
               if (accept && bus.in_last)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (!bus.mem_we || wr_fire) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed self-checking bench for instr_enc_loader. Expectations adapt to
// whether ENC_RANGE_CHECK_EN is defined for the build.
module tb_instr_enc_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] wr_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_wr_cyc = 0;

   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   int          wq_cyc[$];

   instr_enc_loader_if #(.ADDR_W(32)) bus ();

   instr_enc_loader #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every completed memory write (sampled mid-cycle, completes at the next rising edge).
   always @(negedge clk) begin
      if (rst_n && bus.mem_we && bus.mem_ready) begin
         wq_addr.push_back(bus.mem_addr);
         wq_data.push_back(bus.mem_wdata);
         wq_cyc.push_back(cyc);
         last_wr_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] a);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = a;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input string tag, input logic [1:0] fmt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input logic last);
      int n = 0;
      bus.in_valid  = 1'b1;
      bus.in_fmt    = fmt;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_imm    = imm;
      bus.in_last   = last;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                               output int c);
      c = -1;
      check({tag, "_present"}, 64'(wq_addr.size() != 0), 64'd1);
      if (wq_addr.size() != 0) begin
         check({tag, "_addr"}, 64'(wq_addr.pop_front()), 64'(a));
         check({tag, "_data"}, 64'(wq_data.pop_front()), 64'(d));
         c = wq_cyc.pop_front();
      end
   endtask

   task automatic wait_done(input string tag, input bit chk_cyc);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      if (chk_cyc)
         check({tag, "_done_cyc"}, 64'(cyc), 64'(last_wr_cyc + 1));
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int c0, c1, c2;
      bus.in_valid  = 1'b0;
      bus.in_fmt    = 2'b00;
      bus.in_rd     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.in_funct3 = '0;
      bus.in_imm    = '0;
      bus.in_last   = 1'b0;
      bus.mem_ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_mem_we",   64'(bus.mem_we),   64'd0);
      check("rst_busy",     64'(busy),         64'd0);
      check("rst_done",     64'(done),         64'd0);
      check("rst_err",      64'(err),          64'd0);
      check("rst_addr",     64'(bus.mem_addr), 64'd0);
      check("rst_wdata",    64'(bus.mem_wdata), 64'd0);
      check("rst_wr_count", 64'(wr_count),     64'd0);
      rst_n = 1'b1;

      // Session 1: single S-type store, imm=-4
      do_start(32'h100);
      check("s1_busy", 64'(busy), 64'd1);
      send("s1_sw", 2'b00, 5'd0, 5'd2, 5'd5, 3'b010, 32'hFFFF_FFFC, 1'b1);
      wait_done("s1", 1'b1);
      expect_write("s1_w0", 32'h100, 32'hFE51_2E23, c0);
      check("s1_wr_count", 64'(wr_count), 64'd1);

      // Session 2: load then ALU-imm back to back
      do_start(32'h100);
      send("s2_lw",   2'b01, 5'd3, 5'd0, 5'd0, 3'b010, 32'd8,    1'b0);
      send("s2_addi", 2'b10, 5'd1, 5'd1, 5'd0, 3'b000, 32'd2047, 1'b1);
      wait_done("s2", 1'b1);
      expect_write("s2_w0", 32'h100, 32'h0080_2183, c1);
      expect_write("s2_w1", 32'h104, 32'h7FF0_8093, c2);
      check("s2_b2b", 64'(c2 - c1), 64'd1);
      check("s2_wr_count", 64'(wr_count), 64'd2);
      check("s2_err", 64'(err), 64'd0);

      // Session 3: branch imm=-8 with in_last
      do_start(32'h100);
      send("s3_beq", 2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 32'hFFFF_FFF8, 1'b1);
      wait_done("s3", 1'b1);
      expect_write("s3_w0", 32'h100, 32'hFE20_8CE3, c0);

      // Session 4: range check on ALU imm=2048, B imm=6, B imm=3
      do_start(32'h200);
      send("s4_addi", 2'b10, 5'd1, 5'd1, 5'd0, 3'b000, 32'd2048, 1'b0);
`ifdef ENC_RANGE_CHECK_EN
      check("s4_err_early", 64'(err), 64'd1);
`else
      check("s4_err_early", 64'(err), 64'd0);
`endif
      send("s4_b6", 2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 32'd6, 1'b0);
      send("s4_b3", 2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3, 1'b1);
      wait_done("s4", 1'b0);
`ifdef ENC_RANGE_CHECK_EN
      expect_write("s4_w0", 32'h200, 32'h0000_0363, c0);
      check("s4_err", 64'(err), 64'd1);
      check("s4_wr_count", 64'(wr_count), 64'd1);
`else
      expect_write("s4_w0", 32'h200, 32'h8000_8093, c0);
      expect_write("s4_w1", 32'h204, 32'h0000_0363, c0);
      expect_write("s4_w2", 32'h208, 32'h0000_0163, c0);
      check("s4_err", 64'(err), 64'd0);
      check("s4_wr_count", 64'(wr_count), 64'd3);
`endif
      check("s4_no_extra", 64'(wq_addr.size()), 64'd0);

      // Session 5: stalled write, then restart during the stall
      bus.mem_ready = 1'b0;
      do_start(32'h300);
      check("s5_err_clr", 64'(err), 64'd0);
      check("s5_cnt_clr", 64'(wr_count), 64'd0);
      send("s5_sw", 2'b00, 5'd0, 5'd2, 5'd5, 3'b010, 32'hFFFF_FFFC, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_fmt   = 2'b01;
      bus.in_imm   = 32'd8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s5_stall_ready", 64'(bus.in_ready),  64'd0);
         check("s5_stall_we",    64'(bus.mem_we),    64'd1);
         check("s5_stall_addr",  64'(bus.mem_addr),  64'h300);
         check("s5_stall_data",  64'(bus.mem_wdata), 64'hFE51_2E23);
      end
      bus.in_valid = 1'b0;
      do_start(32'h400);
      check("s5_restart_we", 64'(bus.mem_we), 64'd0);
      check("s5_restart_cnt", 64'(wr_count), 64'd0);
      bus.mem_ready = 1'b1;
      send("s5_lw", 2'b01, 5'd3, 5'd0, 5'd0, 3'b010, 32'd8, 1'b1);
      wait_done("s5", 1'b1);
      expect_write("s5_w0", 32'h400, 32'h0080_2183, c0);
      check("s5_no_extra", 64'(wq_addr.size()), 64'd0);

      // Session 6: address wrap from 0xFFFFFFFC
      do_start(32'hFFFF_FFFC);
      send("s6_sw", 2'b00, 5'd0, 5'd2, 5'd5, 3'b010, 32'hFFFF_FFFC, 1'b0);
      send("s6_lw", 2'b01, 5'd3, 5'd0, 5'd0, 3'b010, 32'd8, 1'b1);
      wait_done("s6", 1'b1);
      expect_write("s6_w0", 32'hFFFF_FFFC, 32'hFE51_2E23, c0);
      expect_write("s6_w1", 32'h0000_0000, 32'h0080_2183, c1);
      check("s6_wr_count", 64'(wr_count), 64'd2);

      // Session 7: asynchronous reset mid-burst with a pending write
      bus.mem_ready = 1'b0;
      do_start(32'h500);
      send("s7_sw", 2'b00, 5'd0, 5'd2, 5'd5, 3'b010, 32'hFFFF_FFFC, 1'b0);
      @(negedge clk);
      check("s7_pre_we",   64'(bus.mem_we), 64'd1);
      check("s7_pre_busy", 64'(busy),       64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("s7_rst_in_ready", 64'(bus.in_ready),  64'd0);
      check("s7_rst_we",       64'(bus.mem_we),    64'd0);
      check("s7_rst_busy",     64'(busy),          64'd0);
      check("s7_rst_done",     64'(done),          64'd0);
      check("s7_rst_err",      64'(err),           64'd0);
      check("s7_rst_addr",     64'(bus.mem_addr),  64'd0);
      check("s7_rst_wdata",    64'(bus.mem_wdata), 64'd0);
      check("s7_rst_cnt",      64'(wr_count),      64'd0);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("s7_post_idle", 64'(busy), 64'd0);
      check("s7_lost_write", 64'(wq_addr.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_enc_loader.md
# instr_enc_loader

Instruction encoder and loader for the single-cycle RISC-V core. It accepts decoded instruction fields (format, registers, funct3, 32-bit immediate) over a valid/ready stream and packs each into a 32-bit RV32I word. It then writes the word to instruction memory at sequential word addresses. It is the inverse of the core's immediate extractor and fills program memory from the testbench or a host loader before the core is released from reset.

## Interface
- `ADDR_W`, 32: width of the memory address and base address.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that (re)starts a load session at `base_addr`.
- `base_addr`  in  ADDR_W  first write address, sampled on `start`; must be 4-byte aligned.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  bundle accepted when `in_valid && in_ready`.
- `in_fmt`  in  2  00 store (S, opcode 0100011), 01 load (I, 0000011), 10 ALU-imm (I, 0010011), 11 branch (B, 1100011).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register fields.
- `in_funct3`  in  3  funct3 field.
- `in_imm`  in  32  signed immediate as a byte offset (for B, the branch offset).
- `in_last`  in  1  marks the final bundle of the session.
- `mem_we`  out  1  write request.
- `mem_ready`  in  1  memory accepts the write when `mem_we && mem_ready`.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  encoded instruction.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse at the end of a session.
- `err`  out  1  sticky: at least one bundle was rejected this session.
- `wr_count`  out  16  words written this session, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN when an accepted bundle has `in_last` set.
  - DRAIN→IDLE when no write is pending. `done` pulses on this transition.
- `start` in any state:
  - Loads the address pointer from `base_addr`.
  - Clears `err` and `wr_count`.
  - Discards any pending write.
  - Enters RUN.
- Output register:
  - There is a single-entry output register.
  - `in_ready = (state==RUN) && (!mem_we || mem_ready) && !start`.
- Encoding (`imm` = `in_imm`):
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - I (load/ALU): {imm[11:0], rs1, funct3, rd, opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
- Range check (see Configuration):
  - S/I: `in_imm[31:11]` must be all equal.
  - B: `in_imm[31:12]` must be all equal and `in_imm[0]` must be 0.
  - A failing bundle is still handshaken, produces no write, and sets `err`.
  - If the failing bundle carries `in_last`, the FSM still enters DRAIN.
- Address and count updates on each completed write (`mem_we && mem_ready`):
  - The address pointer increases by 4 and wraps modulo 2^ADDR_W.
  - `wr_count` increments.
- `mem_addr` holds the address of the word in the output register.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `wr_count` = 0.
- Latency: a bundle accepted at edge k drives `mem_we`=1 with valid `mem_addr`/`mem_wdata` after edge k.
- Handshake:
  - `mem_we`, `mem_addr` and `mem_wdata` stay stable until the cycle in which `mem_ready`=1.
  - If a new bundle is accepted in that same cycle, `mem_we` stays 1 with the new word. Sustained throughput is 1 word/cycle.
- `err` updates at the edge after the rejected bundle is accepted.
- `done` is high for exactly one cycle. It is the cycle after the last write completes, or after the last bundle is accepted if no write is pending.
- `rst_n` low mid-session: all outputs return to reset values immediately (asynchronously), and the pending write is lost.

## Configuration
- `ENC_RANGE_CHECK_EN` defined:
  - Range check active as above.
- `ENC_RANGE_CHECK_EN` undefined:
  - No check is performed; every bundle is written.
  - Out-of-range immediates are silently truncated to the encoded bits.
  - `err` is tied to 0.

## Test plan
- Reset, then `start` with `base_addr`=0x100. Send S rs1=2, rs2=5, funct3=010, imm=-4 → `mem_addr`=0x100, `mem_wdata`=0xFE512E23. Feeding that word to the core immediate extractor yields 0xFFFFFFFC.
- Send I load rd=3, rs1=0, funct3=010, imm=8, then I ALU-imm rd=1, rs1=1, imm=2047, with `mem_ready` tied 1 → writes 0x00802183 @0x100 and 0x7FF08093 @0x104 on back-to-back cycles. `wr_count`=2.
- Send B rs1=1, rs2=2, funct3=000, imm=-8 with `in_last` → `mem_wdata`=0xFE208CE3. The extractor gives 0xFFFFFFFC (offset>>1). `done` pulses one cycle after the write and the FSM returns to IDLE.
- With `ENC_RANGE_CHECK_EN`: send ALU-imm imm=2048, then B imm=6 (odd offset bit clear but valid), then B imm=3 → the first and third are rejected without writes. `err`=1, and the single write lands at `base_addr`.
- Hold `mem_ready`=0 for 5 cycles with `mem_we`=1 → `in_ready`=0 and `mem_addr`/`mem_wdata` stay stable. Pulse `start` during the stall → the pending write is dropped, the pointer reloads, and `err`/`wr_count` clear.
- Assert `rst_n`=0 asynchronously mid-burst → all outputs return to 0 before the next edge. `base_addr`=0xFFFFFFFC with two writes → the second address wraps to 0x0.
